ram_sync_be: RTL and testbench

- Single-clock simple dual-port RAM (one write port, one read port), parametrised in width and depth.
- Adds per-byte write enables, a selectable read latency and a selectable read-during-write result.
- After reset, a sequential sweep zeroes the whole array.
- Building block for register files, FIFOs and scratch buffers in designs where both ports share one clock domain.

---
 rtl/ram_sync_be.sv | 122 ++++++++++++
 tb/tb_ram_sync_be.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sync_be.sv
// Simple dual-port synchronous RAM with per-byte write enables, 1- or 2-cycle read latency,
// selectable read-during-write result and an optional zeroing sweep after reset.
module ram_sync_be #(
  parameter int unsigned A_WIDTH        = 5,
  parameter int unsigned D_WIDTH        = 32,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned RDW_NEW        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write_enable,
  input  logic [A_WIDTH-1:0]   address_write,
  input  logic [D_WIDTH-1:0]   data_write,
  input  logic [D_WIDTH/8-1:0] byte_enable,
  input  logic                 read_enable,
  input  logic [A_WIDTH-1:0]   address_read,
  output logic [D_WIDTH-1:0]   data_read,
  output logic                 read_valid,
  output logic                 init_busy
);

  localparam int unsigned DEPTH = 2 ** A_WIDTH;
  localparam int unsigned NB    = D_WIDTH / 8;

  typedef enum logic {StClear, StRun} state_e;

  localparam state_e ResetState = (CLEAR_ON_RESET != 0) ? StClear : StRun;

  state_e               state_q, state_d;
  logic [A_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic [D_WIDTH-1:0]   mem [DEPTH];
  logic [D_WIDTH-1:0]   wr_merged;
  logic [D_WIDTH-1:0]   rd_word;
  logic                 wr_go, rd_go, clr_go;
  logic [D_WIDTH-1:0]   rd_data_q;
  logic                 rd_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ResetState;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StClear: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) state_d = StRun;
      end
      StRun: ;
      default: state_d = ResetState;
    endcase
  end

  // The array has no reset; gating with rst keeps it untouched while reset is held.
  assign clr_go = (state_q == StClear) && !rst;
  assign wr_go  = (state_q == StRun) && write_enable && !rst;
  assign rd_go  = (state_q == StRun) && read_enable && !rst;

  always_comb begin
    wr_merged = mem[address_write];
    for (int i = 0; i < NB; i++) begin
      if (byte_enable[i]) wr_merged[8*i +: 8] = data_write[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (clr_go) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_go) begin
      for (int i = 0; i < NB; i++) begin
        if (byte_enable[i]) mem[address_write][8*i +: 8] <= data_write[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word = mem[address_read];
    if ((RDW_NEW != 0) && wr_go && (address_write == address_read)) rd_word = wr_merged;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_go;
      if (rd_go) rd_data_q <= rd_word;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [D_WIDTH-1:0] out_data_q;
    logic               out_valid_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
      end else begin
        out_valid_q <= rd_valid_q;
        if (rd_valid_q) out_data_q <= rd_data_q;
      end
    end

    assign data_read  = out_data_q;
    assign read_valid = out_valid_q;
  end else begin : g_lat1
    assign data_read  = rd_data_q;
    assign read_valid = rd_valid_q;
  end

  assign init_busy = (state_q == StClear);

endmodule

// File: tb/tb_ram_sync_be.sv
// Drives four differently configured RAM instances with shared stimulus and checks each
// against a word-array model with a scheduled read-result delay.
module tb_ram_sync_be;

  localparam int N = 4;
  // Per instance: 2-cycle latency, new-data read-during-write, clear on reset.
  localparam logic [3:0] LAT2 = 4'b1010;
  localparam logic [3:0] RDWN = 4'b0110;
  localparam logic [3:0] CLR  = 4'b0011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic we = 1'b0, re = 1'b0;
  logic [4:0] aw = '0, ar = '0;
  logic [31:0] wd = '0;
  logic [3:0] be = '0;

  logic [N-1:0][31:0] dr;
  logic [N-1:0] rv, ib;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    ram_sync_be #(
      .A_WIDTH       (5),
      .D_WIDTH       (32),
      .RD_LATENCY    (LAT2[g] ? 2 : 1),
      .RDW_NEW       (RDWN[g] ? 1 : 0),
      .CLEAR_ON_RESET(CLR[g] ? 1 : 0)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .write_enable (we),
      .address_write(aw),
      .data_write   (wd),
      .byte_enable  (be),
      .read_enable  (re),
      .address_read (ar),
      .data_read    (dr[g]),
      .read_valid   (rv[g]),
      .init_busy    (ib[g])
    );
  end

  logic [31:0] m  [N][32];
  bit          kn [N][32];
  bit          busy [N];
  int          cnt  [N];
  bit          ev [N], ek [N], pv [N], pk [N];
  logic [31:0] ed [N], pd [N];

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      busy[k] = CLR[k];
      cnt[k]  = 0;
      ev[k] = 0; ek[k] = 1; ed[k] = '0;
      pv[k] = 0; pk[k] = 1; pd[k] = '0;
    end
  endtask

  // Applies one clock edge to the model using the inputs held across that edge.
  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < N; k++) begin
      bit acc, wk;
      logic [31:0] word;
      acc  = !busy[k] && re;
      word = m[k][ar];
      wk   = kn[k][ar];
      if (RDWN[k] && !busy[k] && we && (aw == ar)) begin
        word = merge(m[k][aw], wd, be);
        wk   = kn[k][aw] || (be == 4'hF);
      end
      if (LAT2[k]) begin
        ev[k] = pv[k];
        if (pv[k]) begin ed[k] = pd[k]; ek[k] = pk[k]; end
        pv[k] = acc;
        if (acc) begin pd[k] = word; pk[k] = wk; end
      end else begin
        ev[k] = acc;
        if (acc) begin ed[k] = word; ek[k] = wk; end
      end
      if (busy[k]) begin
        m[k][cnt[k]]  = '0;
        kn[k][cnt[k]] = 1;
        if (cnt[k] == 31) busy[k] = 0;
        cnt[k]++;
      end else if (we && (be != 4'h0)) begin
        m[k][aw]  = merge(m[k][aw], wd, be);
        kn[k][aw] = kn[k][aw] || (be == 4'hF);
      end
    end
  endtask

  task automatic compare();
    for (int k = 0; k < N; k++) begin
      check($sformatf("init_busy[%0d]", k), 32'(ib[k]), 32'(busy[k]));
      check($sformatf("read_valid[%0d]", k), 32'(rv[k]), 32'(ev[k]));
      if (ek[k]) check($sformatf("data_read[%0d]", k), dr[k], ed[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    compare();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
    we = 1'b1; aw = a; wd = d; be = b;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a);
    re = 1'b1; ar = a;
    tick();
    re = 1'b0;
  endtask

  initial begin
    int n, c0, c1;
    for (int k = 0; k < N; k++)
      for (int a = 0; a < 32; a++) begin m[k][a] = '0; kn[k][a] = 0; end
    model_reset();

    tick();
    tick();
    rst = 1'b0;

    n = 0;
    while (ib[0] && n < 100) begin tick(); n++; end
    check("sweep_len", n, 32);

    c0 = 0; c1 = 0;
    for (int a = 0; a < 32; a++) begin
      re = 1'b1; ar = 5'(a);
      tick();
      c0 += int'(rv[0]); c1 += int'(rv[1]);
    end
    re = 1'b0;
    tick(); c0 += int'(rv[0]); c1 += int'(rv[1]);
    tick(); c0 += int'(rv[0]); c1 += int'(rv[1]);
    check("valid_count0", c0, 32);
    check("valid_count1", c1, 32);
    check("clear_data1", dr[1], 32'h0);

    wr(5'h1B, 32'hDEADBEEF, 4'hF);
    wr(5'h1B, 32'h11223344, 4'h5);
    rd(5'h1B);
    tick();
    check("be_merge0", dr[0], 32'hDE22BE44);
    check("be_merge1", dr[1], 32'hDE22BE44);
    wr(5'h1B, 32'hFFFFFFFF, 4'h0);
    rd(5'h1B);
    tick();
    check("be_zero0", dr[0], 32'hDE22BE44);
    check("be_zero3", dr[3], 32'hDE22BE44);

    wr(5'h03, 32'hAAAAAAAA, 4'hF);
    we = 1'b1; aw = 5'h03; wd = 32'h55555555; be = 4'hF; re = 1'b1; ar = 5'h03;
    tick();
    we = 1'b0; re = 1'b0;
    tick();
    check("rdw_old0", dr[0], 32'hAAAAAAAA);
    check("rdw_new1", dr[1], 32'h55555555);
    check("rdw_new2", dr[2], 32'h55555555);
    check("rdw_old3", dr[3], 32'hAAAAAAAA);
    rd(5'h03);
    tick();
    check("rdw_after0", dr[0], 32'h55555555);
    check("rdw_after1", dr[1], 32'h55555555);

    wr(5'h00, 32'd1, 4'hF);
    wr(5'h01, 32'd2, 4'hF);
    wr(5'h02, 32'd3, 4'hF);
    re = 1'b1; ar = 5'h00;
    tick();
    check("lat2_first_valid", 32'(rv[1]), 32'd0);
    ar = 5'h01;
    tick();
    check("lat2_d1", dr[1], 32'd1);
    ar = 5'h02;
    tick();
    check("lat2_d2", dr[1], 32'd2);
    re = 1'b0;
    tick();
    check("lat2_d3", dr[1], 32'd3);
    check("lat2_v3", 32'(rv[1]), 32'd1);
    tick();
    check("lat2_vend", 32'(rv[1]), 32'd0);

    for (int i = 0; i < 600; i++) begin
      we = 1'($urandom);
      aw = 5'($urandom);
      wd = $urandom;
      be = 4'($urandom);
      re = 1'($urandom);
      ar = (($urandom % 3) == 0) ? aw : 5'($urandom);
      tick();
    end
    we = 1'b0; re = 1'b0;
    tick();
    tick();

    wr(5'h1F, 32'h000000C5, 4'hF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    we = 1'b1; aw = 5'h1B; wd = 32'h000000C5; be = 4'hF; re = 1'b1; ar = 5'h1B;
    tick();
    we = 1'b0;
    tick();
    re = 1'b0;
    check("nocl_rd2", dr[2], 32'h000000C5);
    check("clr_novalid0", 32'(rv[0]), 32'd0);
    n = 2;
    while (ib[0] && n < 100) begin tick(); n++; end
    check("resweep_len", n, 32);
    rd(5'h1F);
    tick();
    check("resweep_data0", dr[0], 32'h0);
    check("resweep_data1", dr[1], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
